// File: rtl/pattern_sequencer.sv
// Pattern buffer playback engine: steps a field pointer through 0..last_field,
// registers each field onto pattern_out and holds it for step_div+1 HOLD cycles.
module pattern_sequencer #(
    parameter int BUFFER_WIDTH = 8,
    parameter int BUFFER_SIZE  = 32,
    parameter int PTR_WIDTH    = 5,
    parameter int DIV_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [PTR_WIDTH-1:0]    last_field,
    input  logic [DIV_WIDTH-1:0]    step_div,
    input  logic [PTR_WIDTH-1:0]    host_fieldp,
    input  logic [BUFFER_WIDTH-1:0] field_byte,
    output logic [PTR_WIDTH-1:0]    fieldp,
    output logic [BUFFER_WIDTH-1:0] pattern_out,
    output logic                    busy,
    output logic                    step_strobe,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [PTR_WIDTH-1:0]   ptr, last_sh;
    logic [DIV_WIDTH-1:0]   cnt, div_sh;

    logic accept, load_edge, expire, at_last, finish;

    // start/stop interaction: stop always wins, start only matters in IDLE.
    assign accept    = (state == IDLE) && start && !stop;
    assign load_edge = (state == LOAD) && !stop;
    assign expire    = (state == HOLD) && !stop && (cnt == '0);
    assign at_last   = (ptr == last_sh);
    assign finish    = expire && at_last && !loop_en;

    assign busy   = (state != IDLE);
    assign fieldp = busy ? ptr : host_fieldp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = stop ? IDLE : HOLD;
            end
            HOLD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = (!at_last || loop_en) ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            last_sh     <= '0;
            div_sh      <= '0;
            cnt         <= '0;
            pattern_out <= '0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            step_strobe <= load_edge;
            done        <= finish;
            if (accept) begin
                ptr     <= '0;
                last_sh <= last_field;
                div_sh  <= step_div;
            end
            if (load_edge) begin
                pattern_out <= field_byte;
                cnt         <= div_sh;
            end
            if ((state == HOLD) && !stop) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!at_last) begin
                    ptr <= ptr + 1'b1;
                end else if (loop_en) begin
                    // Wrap is an explicit reload so last_field < BUFFER_SIZE-1 works.
                    ptr <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a behavioural pattern buffer feeds field_byte,
// a scoreboard checks every pattern_out update, tasks check timing per scenario.
module tb_pattern_sequencer;

    localparam int BW = 8;
    localparam int PW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [PW-1:0] last_field = '0;
    logic [DW-1:0] step_div = '0;
    logic [PW-1:0] host_fieldp = 5'd7;
    logic [BW-1:0] field_byte;
    logic [PW-1:0] fieldp;
    logic [BW-1:0] pattern_out;
    logic          busy;
    logic          step_strobe;
    logic          done;

    logic [BW-1:0] pat_mem [32];
    logic [BW-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int strobe_offs[$];
    int done_offs[$];
    int busy_cnt;
    int max_ptr;

    assign field_byte = pat_mem[fieldp];

    pattern_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .last_field  (last_field),
        .step_div    (step_div),
        .host_fieldp (host_fieldp),
        .field_byte  (field_byte),
        .fieldp      (fieldp),
        .pattern_out (pattern_out),
        .busy        (busy),
        .step_strobe (step_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must present the next expected byte.
    always @(negedge clk) begin
        if (!reset && step_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: strobe with pattern_out=%h, nothing expected", pattern_out);
            end else begin
                logic [BW-1:0] e;
                e = exp_q.pop_front();
                if (pattern_out !== e) begin
                    errors++;
                    $display("FAIL sb_pattern: got %h expected %h", pattern_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic kick(input int lf, input int sd, input logic lp);
        last_field = PW'(lf);
        step_div   = DW'(sd);
        loop_en    = lp;
        start      = 1'b1;
        @(posedge clk); #1;
    endtask

    // Records strobe/done offsets (edges after the start edge) without judging them.
    task automatic observe(input int n, input int pulse_at);
        strobe_offs.delete();
        done_offs.delete();
        busy_cnt = 0;
        max_ptr  = 0;
        for (int k = 0; k < n; k++) begin
            start = (k == pulse_at);
            if (step_strobe) strobe_offs.push_back(k);
            if (done) done_offs.push_back(k);
            if (busy) begin
                busy_cnt++;
                if (int'(fieldp) > max_ptr) max_ptr = int'(fieldp);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (pattern_out !== 8'h00 || busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pat=%h busy=%b strobe=%b done=%b, required 00/0/0/0",
                     pattern_out, busy, step_strobe, done);
        end
        checks++;
        if (fieldp !== 5'd7) begin
            errors++;
            $display("FAIL reset_fieldp: got %0d required 7", fieldp);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_oneshot();
        host_fieldp = 5'd9;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        kick(3, 0, 1'b0);
        observe(12, -1);
        checks++;
        if (strobe_offs.size() != 4) begin
            errors++;
            $display("FAIL oneshot_strobe_count: got %0d required 4", strobe_offs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (strobe_offs[i] != 1 + 2 * i) begin
                    errors++;
                    $display("FAIL oneshot_strobe_time: update %0d at %0d required %0d", i, strobe_offs[i], 1 + 2 * i);
                end
            end
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL oneshot_busy: %0d cycles required 8", busy_cnt);
        end
        checks++;
        if (done_offs.size() != 1 || done_offs[0] != 8) begin
            errors++;
            $display("FAIL oneshot_done: %0d pulses, first at %0d, required 1 at 8",
                     done_offs.size(), (done_offs.size() > 0) ? done_offs[0] : -1);
        end
        checks++;
        if (fieldp !== 5'd9) begin
            errors++;
            $display("FAIL oneshot_host_fieldp: got %0d required 9", fieldp);
        end
    endtask

    task automatic test_loop_stop();
        for (int i = 0; i < 4; i++) exp_q.push_back(i[0] ? 8'h22 : 8'h11);
        kick(1, 2, 1'b1);
        observe(14, -1);
        checks++;
        if (strobe_offs.size() != 4) begin
            errors++;
            $display("FAIL loop_strobe_count: got %0d required 4", strobe_offs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (strobe_offs[i] != 1 + 4 * i) begin
                    errors++;
                    $display("FAIL loop_strobe_time: update %0d at %0d required %0d", i, strobe_offs[i], 1 + 4 * i);
                end
            end
        end
        checks++;
        if (done_offs.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_running: done pulses %0d busy %b, required 0 and 1", done_offs.size(), busy);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || pattern_out !== 8'h22) begin
            errors++;
            $display("FAIL loop_stop: busy=%b pat=%h, required 0 and 22", busy, pattern_out);
        end
        observe(6, -1);
        checks++;
        if (strobe_offs.size() != 0 || done_offs.size() != 0 || pattern_out !== 8'h22) begin
            errors++;
            $display("FAIL loop_after_stop: strobes %0d done %0d pat %h, required 0/0/22",
                     strobe_offs.size(), done_offs.size(), pattern_out);
        end
    endtask

    task automatic test_long_div();
        exp_q.push_back(8'h11);
        kick(0, 255, 1'b0);
        observe(262, -1);
        checks++;
        if (strobe_offs.size() != 1 || strobe_offs[0] != 1) begin
            errors++;
            $display("FAIL longdiv_strobe: %0d updates, required 1 at offset 1", strobe_offs.size());
        end
        checks++;
        if (done_offs.size() != 1 || done_offs[0] != 257) begin
            errors++;
            $display("FAIL longdiv_done: %0d pulses, first at %0d, required 1 at 257",
                     done_offs.size(), (done_offs.size() > 0) ? done_offs[0] : -1);
        end
        checks++;
        if (busy_cnt != 257) begin
            errors++;
            $display("FAIL longdiv_busy: %0d cycles required 257", busy_cnt);
        end
    endtask

    task automatic test_async_reset();
        host_fieldp = 5'd4;
        exp_q.push_back(8'h33);
        pat_mem[0] = 8'h33;
        kick(3, 3, 1'b0);
        observe(3, -1);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (pattern_out !== 8'h00 || busy !== 1'b0 || fieldp !== 5'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pat=%h busy=%b fieldp=%0d done=%b, required 00/0/4/0",
                     pattern_out, busy, fieldp, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pat_mem[0] = 8'h11;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        kick(1, 0, 1'b0);
        observe(6, -1);
        checks++;
        if (strobe_offs.size() != 2 || done_offs.size() != 1 || done_offs[0] != 4) begin
            errors++;
            $display("FAIL async_restart: strobes %0d done %0d, required 2 updates and done at 4",
                     strobe_offs.size(), done_offs.size());
        end
    endtask

    task automatic test_busy_start();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        kick(2, 1, 1'b0);
        last_field = 5'd5;
        step_div   = 8'd7;
        observe(12, 2);
        checks++;
        if (strobe_offs.size() != 3) begin
            errors++;
            $display("FAIL busystart_count: got %0d required 3", strobe_offs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (strobe_offs[i] != 1 + 3 * i) begin
                    errors++;
                    $display("FAIL busystart_time: update %0d at %0d required %0d", i, strobe_offs[i], 1 + 3 * i);
                end
            end
        end
        checks++;
        if (done_offs.size() != 1 || done_offs[0] != 9) begin
            errors++;
            $display("FAIL busystart_done: %0d pulses, required 1 at 9", done_offs.size());
        end
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        observe(3, -1);
        checks++;
        if (busy_cnt != 0 || strobe_offs.size() != 0) begin
            errors++;
            $display("FAIL start_stop_idle: busy %0d strobes %0d, required 0/0", busy_cnt, strobe_offs.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'h11); exp_q.push_back(8'h11);
        kick(0, 0, 1'b0);
        observe(8, 2);
        checks++;
        if (strobe_offs.size() != 2 || strobe_offs[0] != 1 || strobe_offs[1] != 4) begin
            errors++;
            $display("FAIL b2b_strobe: %0d updates, required 2 at offsets 1 and 4", strobe_offs.size());
        end
        checks++;
        if (done_offs.size() != 2 || done_offs[0] != 2 || done_offs[1] != 5) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses, required 2 at offsets 2 and 5", done_offs.size());
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 32; i++) begin
            pat_mem[i] = 8'(i);
            exp_q.push_back(8'(i));
        end
        kick(31, 0, 1'b0);
        observe(70, -1);
        checks++;
        if (strobe_offs.size() != 32) begin
            errors++;
            $display("FAIL ramp_count: got %0d required 32", strobe_offs.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (strobe_offs[i] != 1 + 2 * i) begin
                    errors++;
                    $display("FAIL ramp_time: update %0d at %0d required %0d", i, strobe_offs[i], 1 + 2 * i);
                end
            end
        end
        checks++;
        if (max_ptr != 31 || done_offs.size() != 1 || done_offs[0] != 64) begin
            errors++;
            $display("FAIL ramp_end: max ptr %0d, done pulses %0d, required 31 and 1 at 64",
                     max_ptr, done_offs.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) pat_mem[i] = 8'(($urandom_range(0, 255)));
        pat_mem[0] = 8'h11;
        pat_mem[1] = 8'h22;
        pat_mem[2] = 8'h33;
        pat_mem[3] = 8'h44;
        test_reset();
        test_oneshot();
        test_loop_stop();
        test_long_div();
        test_async_reset();
        test_busy_start();
        test_back_to_back();
        test_ramp();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected updates never seen", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
